axi_fault_monitor: RTL and testbench

Synthesizable, parametrised AXI4 access-fault monitor. It replaces the simulation-only response checker and sits passively on one AXI master/slave link, e.g. the CPU LSU or IFU port. Accepted AR/AW addresses are queued per direction so every non-OKAY response is reported with its originating address, ID and cause. The block also detects response timeouts, unexpected responses and tracker overflow. It holds the first fault sticky until software or the trap logic clears it.

---
 rtl/axi_mon_pkg.sv | 36 +++
 rtl/axi_mon_track_fifo.sv | 49 ++++
 rtl/axi_fault_monitor.sv | 222 ++++++++++++++++++++++
 tb/tb_axi_fault_monitor.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mon_pkg.sv
// Shared types and constants for the AXI access-fault monitor.
package axi_mon_pkg;

    // Cause codes, listed from "no fault" to "tracker overflow".
    typedef enum logic [2:0] {
        CAUSE_NONE     = 3'd0,
        CAUSE_RRESP    = 3'd1,
        CAUSE_BRESP    = 3'd2,
        CAUSE_RTIMEOUT = 3'd3,
        CAUSE_WTIMEOUT = 3'd4,
        CAUSE_RUNEXP   = 3'd5,
        CAUSE_BUNEXP   = 3'd6,
        CAUSE_OVERFLOW = 3'd7
    } fault_cause_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Default-width tracking entry; the top mirrors this layout at its own
    // ADDR_W/ID_W parameters because a package type cannot be parametrised.
    localparam int TRACK_ADDR_W = 32;
    localparam int TRACK_ID_W   = 4;

    typedef struct packed {
        logic [TRACK_ADDR_W-1:0] addr;
        logic [TRACK_ID_W-1:0]   id;
    } track_entry_t;

    // Anything other than OKAY (including EXOKAY) is treated as a fault.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_mon_track_fifo.sv
// In-order tracker FIFO holding the outstanding {addr, id} entries of one
// AXI direction. A push into a full FIFO is dropped unless a pop happens in
// the same cycle; a pop from an empty FIFO is ignored.
module axi_mon_track_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[PW-1:0]];

    // Advance the read and write pointers on accepted pops and pushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Entry storage needs no reset; only slots behind the pointers are read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/axi_fault_monitor.sv
// Passive AXI4 access-fault monitor: tracks outstanding reads and writes,
// flags error responses, timeouts, unexpected responses and tracker
// overflow, and keeps the first fault as a sticky record.
module axi_fault_monitor #(
    parameter int ADDR_W    = 32,
    parameter int ID_W      = 4,
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 1024,
    parameter int SIM_FATAL = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              awvalid,
    input  logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [ID_W-1:0]   awid,
    input  logic              bvalid,
    input  logic              bready,
    input  logic [1:0]        bresp,
    input  logic [ID_W-1:0]   bid,
    input  logic              arvalid,
    input  logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [ID_W-1:0]   arid,
    input  logic              rvalid,
    input  logic              rready,
    input  logic              rlast,
    input  logic [1:0]        rresp,
    input  logic [ID_W-1:0]   rid,
    input  logic              fault_clr,
    output logic              access_fault,
    output logic              fault_valid,
    output logic [2:0]        fault_cause,
    output logic [ADDR_W-1:0] fault_addr,
    output logic [ID_W-1:0]   fault_id,
    output logic [1:0]        fault_resp,
    output logic [15:0]       fault_cnt
);

    import axi_mon_pkg::*;

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
    } entry_t;

    typedef struct packed {
        fault_cause_e      cause;
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
        logic [1:0]        resp;
    } record_t;

    entry_t        rd_din, rd_head, wr_din, wr_head;
    logic          rd_full, rd_empty, wr_full, wr_empty;
    logic          r_push, r_beat, r_pop, w_push, w_beat, w_pop;
    logic [TW-1:0] r_to_cnt, w_to_cnt;
    logic          r_to_fired, w_to_fired;
    logic          det_rresp, det_bresp, det_rto, det_wto;
    logic          det_runexp, det_bunexp, det_rovf, det_wovf;
    logic [7:0]    det_vec;
    logic          any_det;
    logic [3:0]    n_det;
    logic [16:0]   cnt_sum;
    logic [15:0]   cnt_next;
    record_t       new_rec, rec_q;

    assign r_push = arvalid && arready;
    assign r_beat = rvalid && rready;
    assign r_pop  = r_beat && rlast;
    assign w_push = awvalid && awready;
    assign w_beat = bvalid && bready;
    assign w_pop  = w_beat;

    assign rd_din = '{addr: araddr, id: arid};
    assign wr_din = '{addr: awaddr, id: awid};

    axi_mon_track_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_rd_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (r_push),
        .pop   (r_pop),
        .din   (rd_din),
        .full  (rd_full),
        .empty (rd_empty),
        .head  (rd_head)
    );

    axi_mon_track_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_wr_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (wr_din),
        .full  (wr_full),
        .empty (wr_empty),
        .head  (wr_head)
    );

    // An error response needs a tracked head to blame; with nothing
    // outstanding the beat is reported as unexpected instead.
    assign det_rresp  = r_beat && !rd_empty && resp_is_error(rresp);
    assign det_bresp  = w_beat && !wr_empty && resp_is_error(bresp);
    assign det_runexp = r_beat && rd_empty;
    assign det_bunexp = w_beat && wr_empty;
    assign det_rovf   = r_push && rd_full && !r_pop;
    assign det_wovf   = w_push && wr_full && !w_pop;
    assign det_rto    = !rd_empty && (r_to_cnt == TO_LAST) && !r_to_fired;
    assign det_wto    = !wr_empty && (w_to_cnt == TO_LAST) && !w_to_fired;

    assign det_vec  = {det_bresp, det_rresp, det_wto, det_rto,
                       det_bunexp, det_runexp, det_rovf, det_wovf};
    assign any_det  = |det_vec;
    assign n_det    = 4'($countones(det_vec));
    assign cnt_sum  = {1'b0, fault_cnt} + 17'(n_det);
    assign cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

    // Read wait counter: idle while empty, restarted by every R beat,
    // parked at the limit once reached.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= '0;
        end else if (rd_empty || r_beat) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TO_LAST) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Write wait counter, same behaviour driven by B beats.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            w_to_cnt <= '0;
        end else if (wr_empty || w_beat) begin
            w_to_cnt <= '0;
        end else if (w_to_cnt != TO_LAST) begin
            w_to_cnt <= w_to_cnt + 1'b1;
        end
    end

    // Remember that the current heads already timed out so each is
    // reported once, until it finally pops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_fired <= 1'b0;
            w_to_fired <= 1'b0;
        end else begin
            if (rd_empty || r_pop) r_to_fired <= 1'b0;
            else if (det_rto)      r_to_fired <= 1'b1;
            if (wr_empty || w_pop) w_to_fired <= 1'b0;
            else if (det_wto)      w_to_fired <= 1'b1;
        end
    end

    // Pick the record for this cycle's highest-priority fault; when both
    // directions overflow together the read side is kept.
    always_comb begin
        new_rec = '0;
        if (det_bresp) begin
            new_rec = '{cause: CAUSE_BRESP, addr: wr_head.addr, id: wr_head.id, resp: bresp};
        end else if (det_rresp) begin
            new_rec = '{cause: CAUSE_RRESP, addr: rd_head.addr, id: rd_head.id, resp: rresp};
        end else if (det_wto) begin
            new_rec = '{cause: CAUSE_WTIMEOUT, addr: wr_head.addr, id: wr_head.id, resp: 2'b00};
        end else if (det_rto) begin
            new_rec = '{cause: CAUSE_RTIMEOUT, addr: rd_head.addr, id: rd_head.id, resp: 2'b00};
        end else if (det_bunexp) begin
            new_rec = '{cause: CAUSE_BUNEXP, addr: '0, id: bid, resp: 2'b00};
        end else if (det_runexp) begin
            new_rec = '{cause: CAUSE_RUNEXP, addr: '0, id: rid, resp: 2'b00};
        end else if (det_rovf) begin
            new_rec = '{cause: CAUSE_OVERFLOW, addr: araddr, id: arid, resp: 2'b00};
        end else if (det_wovf) begin
            new_rec = '{cause: CAUSE_OVERFLOW, addr: awaddr, id: awid, resp: 2'b00};
        end
    end

    // Pulse, counter and sticky record; a fault arriving with fault_clr
    // survives the clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            access_fault <= 1'b0;
            fault_valid  <= 1'b0;
            fault_cnt    <= '0;
            rec_q        <= '0;
        end else begin
            access_fault <= any_det;
            if (fault_clr) begin
                fault_cnt   <= {12'd0, n_det};
                fault_valid <= any_det;
                rec_q       <= new_rec;
            end else begin
                fault_cnt <= cnt_next;
                if (!fault_valid && any_det) begin
                    fault_valid <= 1'b1;
                    rec_q       <= new_rec;
                end
            end
        end
    end

    assign fault_cause = rec_q.cause;
    assign fault_addr  = rec_q.addr;
    assign fault_id    = rec_q.id;
    assign fault_resp  = rec_q.resp;

`ifndef SYNTHESIS
    generate
        if (SIM_FATAL != 0) begin : g_sim_fatal
            // Stop simulation at the first captured fault when requested.
            always @(posedge i_clk) begin
                if (i_rst_n && any_det)
                    $fatal(1, "axi_fault_monitor: fault cause %0d", new_rec.cause);
            end
        end
    endgenerate
`endif

endmodule

// File: tb/tb_axi_fault_monitor.sv
// Directed bench for axi_fault_monitor with a queue-based reference model
// compared every cycle plus hand-computed checkpoints.
module tb_axi_fault_monitor;

    localparam int ADDR_W  = 32;
    localparam int ID_W    = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b1;
    logic              awvalid = 0, awready = 0, bvalid = 0, bready = 0;
    logic [ADDR_W-1:0] awaddr = '0, araddr = '0;
    logic [ID_W-1:0]   awid = '0, bid = '0, arid = '0, rid = '0;
    logic [1:0]        bresp = '0, rresp = '0;
    logic              arvalid = 0, arready = 0, rvalid = 0, rready = 0, rlast = 0;
    logic              fault_clr = 0;
    logic              access_fault, fault_valid;
    logic [2:0]        fault_cause;
    logic [ADDR_W-1:0] fault_addr;
    logic [ID_W-1:0]   fault_id;
    logic [1:0]        fault_resp;
    logic [15:0]       fault_cnt;

    int errors = 0;
    int checks = 0;

    axi_fault_monitor #(.ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH),
                        .TIMEOUT(TIMEOUT), .SIM_FATAL(0)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp), .rid(rid),
        .fault_clr(fault_clr),
        .access_fault(access_fault), .fault_valid(fault_valid),
        .fault_cause(fault_cause), .fault_addr(fault_addr), .fault_id(fault_id),
        .fault_resp(fault_resp), .fault_cnt(fault_cnt)
    );

    always #5 i_clk = ~i_clk;

    // One comparison: count it, and report it only when it disagrees.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic [31:0] addr; logic [3:0] id; } ent_t;
    typedef struct { bit hit; logic [2:0] cause; logic [31:0] addr; logic [3:0] id; logic [1:0] resp; } cand_t;

    ent_t        rq[$];
    ent_t        wq[$];
    int          cyc = 0;
    int          r_clear = 0, w_clear = 0;
    bit          r_rep = 0, w_rep = 0;
    bit          exp_af = 0, exp_valid = 0;
    logic [2:0]  exp_cause = '0;
    logic [31:0] exp_addr = '0;
    logic [3:0]  exp_id = '0;
    logic [1:0]  exp_resp = '0;
    int          exp_cnt = 0;

    task automatic model_step();
        bit    r_beat = rvalid && rready;
        bit    w_beat = bvalid && bready;
        bit    r_pop  = r_beat && rlast;
        bit    r_push = arvalid && arready;
        bit    w_push = awvalid && awready;
        bit    r_empty = (rq.size() == 0);
        bit    w_empty = (wq.size() == 0);
        ent_t  rh = r_empty ? '0 : rq[0];
        ent_t  wh = w_empty ? '0 : wq[0];
        cand_t c[8];
        int    n = 0;
        int    first = -1;
        // Candidates listed in recording priority order.
        c[0] = '{w_beat && !w_empty && bresp != 2'b00, 3'd2, wh.addr, wh.id, bresp};
        c[1] = '{r_beat && !r_empty && rresp != 2'b00, 3'd1, rh.addr, rh.id, rresp};
        c[2] = '{!w_empty && !w_rep && (cyc - w_clear) >= TIMEOUT - 1, 3'd4, wh.addr, wh.id, 2'b00};
        c[3] = '{!r_empty && !r_rep && (cyc - r_clear) >= TIMEOUT - 1, 3'd3, rh.addr, rh.id, 2'b00};
        c[4] = '{w_beat && w_empty, 3'd6, 32'd0, bid, 2'b00};
        c[5] = '{r_beat && r_empty, 3'd5, 32'd0, rid, 2'b00};
        c[6] = '{r_push && rq.size() == DEPTH && !r_pop, 3'd7, araddr, arid, 2'b00};
        c[7] = '{w_push && wq.size() == DEPTH && !w_beat, 3'd7, awaddr, awid, 2'b00};
        for (int i = 0; i < 8; i++) begin
            if (c[i].hit) begin
                n++;
                if (first < 0) first = i;
            end
        end
        exp_af = (n > 0);
        if (fault_clr || (!exp_valid && n > 0)) begin
            exp_valid = (n > 0);
            exp_cause = (n > 0) ? c[first].cause : 3'd0;
            exp_addr  = (n > 0) ? c[first].addr  : 32'd0;
            exp_id    = (n > 0) ? c[first].id    : 4'd0;
            exp_resp  = (n > 0) ? c[first].resp  : 2'd0;
        end
        exp_cnt = fault_clr ? n : ((exp_cnt + n > 65535) ? 65535 : exp_cnt + n);
        if (r_pop && !r_empty) void'(rq.pop_front());
        if (w_beat && !w_empty) void'(wq.pop_front());
        if (r_push && !c[6].hit) rq.push_back('{araddr, arid});
        if (w_push && !c[7].hit) wq.push_back('{awaddr, awid});
        if (r_empty || r_pop) r_rep = 0; else if (c[3].hit) r_rep = 1;
        if (w_empty || w_beat) w_rep = 0; else if (c[2].hit) w_rep = 1;
        if (r_empty || r_beat) r_clear = cyc + 1;
        if (w_empty || w_beat) w_clear = cyc + 1;
        cyc++;
    endtask

    // Advance the model on each clock edge, or wipe it on reset.
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rq.delete();
            wq.delete();
            r_rep = 0; w_rep = 0;
            exp_af = 0; exp_valid = 0; exp_cause = '0; exp_addr = '0;
            exp_id = '0; exp_resp = '0; exp_cnt = 0;
        end else begin
            model_step();
        end
    end

    // Compare every output with the model away from the active edge.
    always @(negedge i_clk) begin
        checkOutput("cmp access_fault", 32'(access_fault), 32'(exp_af));
        checkOutput("cmp fault_valid",  32'(fault_valid),  32'(exp_valid));
        checkOutput("cmp fault_cause",  32'(fault_cause),  32'(exp_cause));
        checkOutput("cmp fault_addr",   fault_addr,        exp_addr);
        checkOutput("cmp fault_id",     32'(fault_id),     32'(exp_id));
        checkOutput("cmp fault_resp",   32'(fault_resp),   32'(exp_resp));
        checkOutput("cmp fault_cnt",    32'(fault_cnt),    32'(exp_cnt));
    end

    // ---------------- stimulus ----------------
    typedef struct packed {
        logic arvalid; logic [31:0] araddr; logic [3:0] arid;
        logic rvalid; logic rlast; logic [1:0] rresp; logic [3:0] rid;
        logic awvalid; logic [31:0] awaddr; logic [3:0] awid;
        logic bvalid; logic [1:0] bresp; logic [3:0] bid;
        logic clr;
    } stim_t;

    localparam stim_t IDLE = '0;

    function automatic stim_t s_ar(input logic [31:0] a, input logic [3:0] id);
        stim_t s; s = '0; s.arvalid = 1; s.araddr = a; s.arid = id; return s;
    endfunction
    function automatic stim_t s_r(input logic [1:0] resp, input logic [3:0] id, input logic last);
        stim_t s; s = '0; s.rvalid = 1; s.rresp = resp; s.rid = id; s.rlast = last; return s;
    endfunction
    function automatic stim_t s_aw(input logic [31:0] a, input logic [3:0] id);
        stim_t s; s = '0; s.awvalid = 1; s.awaddr = a; s.awid = id; return s;
    endfunction
    function automatic stim_t s_b(input logic [1:0] resp, input logic [3:0] id);
        stim_t s; s = '0; s.bvalid = 1; s.bresp = resp; s.bid = id; return s;
    endfunction
    function automatic stim_t s_clr();
        stim_t s; s = '0; s.clr = 1; return s;
    endfunction

    // Drive one cycle of inputs starting at the falling edge.
    task automatic applyStimulus(input stim_t s);
        @(negedge i_clk);
        arvalid = s.arvalid; arready = s.arvalid; araddr = s.araddr; arid = s.arid;
        rvalid = s.rvalid; rready = s.rvalid; rlast = s.rlast; rresp = s.rresp; rid = s.rid;
        awvalid = s.awvalid; awready = s.awvalid; awaddr = s.awaddr; awid = s.awid;
        bvalid = s.bvalid; bready = s.bvalid; bresp = s.bresp; bid = s.bid;
        fault_clr = s.clr;
    endtask

    initial begin
        #1 i_rst_n = 1'b0;
        repeat (3) applyStimulus(IDLE);
        checkOutput("reset access_fault", 32'(access_fault), 32'd0);
        checkOutput("reset fault_valid",  32'(fault_valid),  32'd0);
        checkOutput("reset fault_cnt",    32'(fault_cnt),    32'd0);
        i_rst_n = 1'b1;
        applyStimulus(IDLE);

        $display("[TB] read SLVERR");
        applyStimulus(s_ar(32'h8000_0000, 4'd3));
        applyStimulus(s_r(2'b10, 4'd3, 1'b1));
        applyStimulus(IDLE);
        checkOutput("t1 access_fault", 32'(access_fault), 32'd1);
        checkOutput("t1 cause", 32'(fault_cause), 32'd1);
        checkOutput("t1 addr",  fault_addr, 32'h8000_0000);
        checkOutput("t1 id",    32'(fault_id), 32'd3);
        checkOutput("t1 resp",  32'(fault_resp), 32'd2);
        checkOutput("t1 cnt",   32'(fault_cnt), 32'd1);

        $display("[TB] write DECERR behind sticky read fault");
        applyStimulus(s_aw(32'h1000_0010, 4'd5));
        applyStimulus(s_b(2'b11, 4'd5));
        applyStimulus(IDLE);
        checkOutput("t2 access_fault", 32'(access_fault), 32'd1);
        checkOutput("t2 cause", 32'(fault_cause), 32'd1);
        checkOutput("t2 addr",  fault_addr, 32'h8000_0000);
        checkOutput("t2 cnt",   32'(fault_cnt), 32'd2);
        applyStimulus(IDLE);
        checkOutput("t2 pulse ends", 32'(access_fault), 32'd0);

        $display("[TB] read timeout");
        applyStimulus(s_clr());
        applyStimulus(IDLE);
        checkOutput("t3 clr valid", 32'(fault_valid), 32'd0);
        checkOutput("t3 clr cnt",   32'(fault_cnt), 32'd0);
        applyStimulus(s_ar(32'h0000_2000, 4'd1));
        repeat (16) applyStimulus(IDLE);
        checkOutput("t3 no early pulse", 32'(access_fault), 32'd0);
        applyStimulus(IDLE);
        checkOutput("t3 pulse", 32'(access_fault), 32'd1);
        checkOutput("t3 cause", 32'(fault_cause), 32'd3);
        checkOutput("t3 resp",  32'(fault_resp), 32'd0);
        checkOutput("t3 addr",  fault_addr, 32'h0000_2000);
        repeat (20) applyStimulus(IDLE);
        checkOutput("t3 single pulse cnt", 32'(fault_cnt), 32'd1);
        applyStimulus(s_r(2'b00, 4'd1, 1'b1));
        applyStimulus(IDLE);
        checkOutput("t3 after response cnt", 32'(fault_cnt), 32'd1);

        $display("[TB] overflow");
        applyStimulus(s_clr());
        for (int i = 0; i < 5; i++)
            applyStimulus(s_ar(32'h0000_0100 + 32'(i * 4), 4'(i)));
        applyStimulus(IDLE);
        checkOutput("t4 cause", 32'(fault_cause), 32'd7);
        checkOutput("t4 addr",  fault_addr, 32'h0000_0110);
        checkOutput("t4 cnt",   32'(fault_cnt), 32'd1);
        applyStimulus(stim_t'(s_r(2'b00, 4'd0, 1'b1) | s_ar(32'h0000_0200, 4'd5)));
        applyStimulus(IDLE);
        checkOutput("t4 full push+pop no fault", 32'(access_fault), 32'd0);
        checkOutput("t4 full push+pop cnt", 32'(fault_cnt), 32'd1);
        for (int i = 1; i < 4; i++) applyStimulus(s_r(2'b00, 4'(i), 1'b1));
        applyStimulus(s_r(2'b00, 4'd5, 1'b1));
        applyStimulus(IDLE);
        checkOutput("t4 drained cnt", 32'(fault_cnt), 32'd1);

        $display("[TB] unexpected B and clear collision");
        applyStimulus(s_clr());
        applyStimulus(s_b(2'b00, 4'd2));
        applyStimulus(IDLE);
        checkOutput("t5 cause", 32'(fault_cause), 32'd6);
        checkOutput("t5 addr",  fault_addr, 32'd0);
        checkOutput("t5 id",    32'(fault_id), 32'd2);
        applyStimulus(s_ar(32'h0000_3000, 4'd6));
        applyStimulus(stim_t'(s_r(2'b10, 4'd6, 1'b1) | s_clr()));
        applyStimulus(IDLE);
        checkOutput("t5 clr+fault valid", 32'(fault_valid), 32'd1);
        checkOutput("t5 clr+fault cause", 32'(fault_cause), 32'd1);
        checkOutput("t5 clr+fault cnt",   32'(fault_cnt), 32'd1);
        checkOutput("t5 clr+fault addr",  fault_addr, 32'h0000_3000);

        $display("[TB] simultaneous read and write errors");
        applyStimulus(s_clr());
        applyStimulus(stim_t'(s_ar(32'h0000_4000, 4'd7) | s_aw(32'h0000_5000, 4'd8)));
        applyStimulus(stim_t'(s_r(2'b11, 4'd7, 1'b1) | s_b(2'b10, 4'd8)));
        applyStimulus(IDLE);
        checkOutput("t6 cause", 32'(fault_cause), 32'd2);
        checkOutput("t6 cnt",   32'(fault_cnt), 32'd2);
        checkOutput("t6 addr",  fault_addr, 32'h0000_5000);
        checkOutput("t6 resp",  32'(fault_resp), 32'd2);

        $display("[TB] reset mid-burst");
        applyStimulus(s_ar(32'h0000_6000, 4'd1));
        applyStimulus(s_r(2'b00, 4'd1, 1'b0));
        applyStimulus(IDLE);
        #3 i_rst_n = 1'b0;
        #1;
        checkOutput("t7 reset access_fault", 32'(access_fault), 32'd0);
        checkOutput("t7 reset valid", 32'(fault_valid), 32'd0);
        checkOutput("t7 reset cause", 32'(fault_cause), 32'd0);
        checkOutput("t7 reset addr",  fault_addr, 32'd0);
        checkOutput("t7 reset cnt",   32'(fault_cnt), 32'd0);
        repeat (2) applyStimulus(IDLE);
        i_rst_n = 1'b1;
        applyStimulus(s_r(2'b00, 4'd1, 1'b1));
        applyStimulus(IDLE);
        checkOutput("t7 post-reset cause", 32'(fault_cause), 32'd5);
        checkOutput("t7 post-reset addr",  fault_addr, 32'd0);
        checkOutput("t7 post-reset id",    32'(fault_id), 32'd1);
        checkOutput("t7 post-reset cnt",   32'(fault_cnt), 32'd1);
        repeat (3) applyStimulus(IDLE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
